cpu_mem_responder: RTL and testbench

Memory-side responder for one CPU port: the instruction port or the data port. It accepts the CPU's read/write/address/byte_enable/wdata/stall request signals and returns resp/ready/rdata with the timing the pipeline expects. It converts each request into word-wide accesses on a multi-cycle physical-memory handshake. Partial-word writes are performed as read-modify-write, because physical memory has no byte enables.

---
 rtl/cpu_mem_responder.sv | 152 +++++++++++++++
 tb/tb_cpu_mem_responder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// CPU-port responder: turns pipeline read/write requests into word-wide physical-memory
// handshakes, doing read-modify-write for partial-word stores.
module cpu_mem_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] wdata,
  input  logic        stall,
  output logic        resp,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [29:0] addr_reg, addr_next;
  logic [3:0]  be_reg, be_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] rbuf_reg, rbuf_next;
  logic        is_read_reg, is_read_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        ready_reg, ready_next;
  logic        pmem_read_reg, pmem_write_reg;
  logic [31:0] merged_word;

  // Address is word-aligned; the byte offset bits carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[1:0];

  // Merge latched store lanes over the word just fetched from memory.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[8*gi +: 8] = be_reg[gi] ? wdata_reg[8*gi +: 8]
                                                 : pmem_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    be_next      = be_reg;
    wdata_next   = wdata_reg;
    rbuf_next    = rbuf_reg;
    is_read_next = is_read_reg;
    rdata_next   = rdata_reg;
    ready_next   = ready_reg;
    unique case (state_reg)
      IDLE: begin
        if (write) begin
          is_read_next = 1'b0;
          if (byte_enable == 4'h0) begin
            state_next = DONE;
          end else begin
            addr_next  = address[31:2];
            wdata_next = wdata;
            if (byte_enable == 4'hF) begin
              state_next = WR;
            end else begin
              be_next    = byte_enable;
              state_next = RMW_RD;
            end
          end
        end else if (read) begin
          addr_next    = address[31:2];
          is_read_next = 1'b1;
          state_next   = RD;
        end
      end
      RD: begin
        if (pmem_resp) begin
          rbuf_next  = pmem_rdata;
          state_next = DONE;
        end
      end
      RMW_RD: begin
        if (pmem_resp) begin
          wdata_next = merged_word;
          state_next = WR;
        end
      end
      WR: begin
        if (pmem_resp) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Read data is published only when the CPU actually advances.
        if (!stall) begin
          state_next = IDLE;
          if (is_read_reg) begin
            rdata_next = rbuf_reg;
            ready_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      be_reg         <= '0;
      wdata_reg      <= '0;
      rbuf_reg       <= '0;
      is_read_reg    <= 1'b0;
      rdata_reg      <= '0;
      ready_reg      <= 1'b0;
      pmem_read_reg  <= 1'b0;
      pmem_write_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      be_reg         <= be_next;
      wdata_reg      <= wdata_next;
      rbuf_reg       <= rbuf_next;
      is_read_reg    <= is_read_next;
      rdata_reg      <= rdata_next;
      ready_reg      <= ready_next;
      // Strobes follow the state being entered, so they drop on the resp edge.
      pmem_read_reg  <= (state_next == RD) || (state_next == RMW_RD);
      pmem_write_reg <= (state_next == WR);
    end
  end

  assign resp         = (state_reg == DONE) || ((state_reg == IDLE) && !read && !write);
  assign ready        = ready_reg;
  assign rdata        = rdata_reg;
  assign pmem_read    = pmem_read_reg;
  assign pmem_write   = pmem_write_reg;
  assign pmem_address = {addr_reg, 2'b00};
  assign pmem_wdata   = wdata_reg;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: directed vector table, randomized transactions checked
// against a transaction-level model, plus a mid-access reset sequence.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read = 1'b0, write = 1'b0, stall = 1'b0;
  logic [31:0] address = '0, wdata = '0;
  logic [3:0]  byte_enable = '0;
  logic        resp, ready;
  logic [31:0] rdata;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address, pmem_wdata;
  logic [31:0] pmem_rdata = '0;
  logic        pmem_resp = 1'b0;

  always #5 clk = ~clk;

  cpu_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .address(address),
    .byte_enable(byte_enable), .wdata(wdata), .stall(stall), .resp(resp),
    .ready(ready), .rdata(rdata), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          stall_n, wa, wb;
    int          exp_done, exp_nacc;
    acc_t        exp_acc0, exp_acc1;
    logic [31:0] exp_rdata;
    logic        exp_ready;
  } vec_t;

  int tests = 0, fails = 0;
  int proto_err = 0;
  int wait_a = 0, wait_b = 0, txn_base = 0;
  acc_t acc_log[$];
  logic [31:0] pmem_mem [bit [29:0]];
  logic [31:0] mem_ref [bit [29:0]];
  logic [31:0] exp_rdata_cur = '0;
  logic        exp_ready_cur = 1'b0;

  // Initial physical-memory contents: a few fixed words, a hash everywhere else.
  function automatic logic [31:0] init_word(input logic [29:0] wi);
    if (wi == 30'h40) return 32'hDEADBEEF;
    if (wi == 30'h80) return 32'h11223344;
    if (wi == 30'hC0) return 32'h55667788;
    return ({2'b00, wi} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Physical memory: responds N wait cycles after a strobe appears, one-cycle pulse.
  int   wait_cnt = 0;
  logic act = 1'b0, last_we = 1'b0;
  logic [31:0] act_addr = '0, act_wdata = '0;
  always @(negedge clk) begin
    int w;
    logic [29:0] wi;
    acc_t e;
    if (!rst_n) begin
      pmem_resp = 1'b0;
      wait_cnt  = 0;
      act       = 1'b0;
    end else begin
      if (pmem_read && pmem_write) proto_err++;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        wait_cnt  = 0;
        act       = 1'b0;
        if ((last_we && pmem_write) || (!last_we && pmem_read)) proto_err++;
      end
      pmem_rdata = $urandom;
      if (pmem_read || pmem_write) begin
        if (act && (pmem_address != act_addr || (pmem_write && pmem_wdata != act_wdata)))
          proto_err++;
        act       = 1'b1;
        act_addr  = pmem_address;
        act_wdata = pmem_wdata;
        w = (acc_log.size() - txn_base == 0) ? wait_a : wait_b;
        if (wait_cnt >= w) begin
          wi = pmem_address[31:2];
          e.we   = pmem_write;
          e.addr = pmem_address;
          if (pmem_write) begin
            pmem_mem[wi] = pmem_wdata;
            e.data = pmem_wdata;
          end else begin
            e.data = pmem_mem.exists(wi) ? pmem_mem[wi] : init_word(wi);
            pmem_rdata = e.data;
          end
          acc_log.push_back(e);
          last_we   = pmem_write;
          pmem_resp = 1'b1;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act_v, exp_v);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wd, input int stall_n,
                              input int wa, input int wb, input int done, input int nacc,
                              input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                              input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                              input logic [31:0] rdv, input logic rdy);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.be = be; v.wd = wd;
    v.stall_n = stall_n; v.wa = wa; v.wb = wb;
    v.exp_done = done; v.exp_nacc = nacc;
    v.exp_acc0.we = we0; v.exp_acc0.addr = a0; v.exp_acc0.data = d0;
    v.exp_acc1.we = we1; v.exp_acc1.addr = a1; v.exp_acc1.data = d1;
    v.exp_rdata = rdv; v.exp_ready = rdy;
    return v;
  endfunction

  // Transaction-level reference: latency, pmem accesses and published data from the rules.
  task automatic predict(inout vec_t v);
    logic [29:0] wi;
    logic [31:0] old, merged, waddr;
    wi    = v.addr[31:2];
    waddr = {v.addr[31:2], 2'b00};
    old   = mem_ref.exists(wi) ? mem_ref[wi] : init_word(wi);
    v.exp_rdata = exp_rdata_cur;
    v.exp_ready = exp_ready_cur;
    v.exp_acc0  = '{1'b0, 32'h0, 32'h0};
    v.exp_acc1  = '{1'b0, 32'h0, 32'h0};
    if (v.wr) begin
      if (v.be == 4'h0) begin
        v.exp_done = 1; v.exp_nacc = 0;
      end else if (v.be == 4'hF) begin
        v.exp_done = v.wa + 2; v.exp_nacc = 1;
        v.exp_acc0 = '{1'b1, waddr, v.wd};
        mem_ref[wi] = v.wd;
      end else begin
        merged = old;
        for (int b = 0; b < 4; b++)
          if (v.be[b]) merged[8*b +: 8] = v.wd[8*b +: 8];
        v.exp_done = v.wa + v.wb + 3; v.exp_nacc = 2;
        v.exp_acc0 = '{1'b0, waddr, old};
        v.exp_acc1 = '{1'b1, waddr, merged};
        mem_ref[wi] = merged;
      end
    end else begin
      v.exp_done = v.wa + 2; v.exp_nacc = 1;
      v.exp_acc0 = '{1'b0, waddr, old};
      v.exp_rdata = old;
      v.exp_ready = 1'b1;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    int base;
    @(posedge clk); #1;
    base     = acc_log.size();
    txn_base = base;
    wait_a   = v.wa;
    wait_b   = v.wb;
    read = v.rd; write = v.wr; address = v.addr; byte_enable = v.be; wdata = v.wd;
    stall = (v.stall_n != 0);
    cyc = 0;
    @(negedge clk);
    while (!resp && cyc < 64) begin
      @(posedge clk); #1;
      address = $urandom; wdata = $urandom; byte_enable = 4'($urandom);
      @(negedge clk);
      cyc++;
    end
    check({tag, ".done_cycle"}, cyc, v.exp_done);
    check({tag, ".rdata_before_advance"}, rdata, exp_rdata_cur);
    for (int i = 0; i < v.stall_n; i++) begin
      check({tag, ".stall_resp"}, resp, 1'b1);
      check({tag, ".stall_no_strobe"}, {pmem_read, pmem_write}, 2'b00);
      check({tag, ".stall_rdata"}, rdata, exp_rdata_cur);
      @(posedge clk); #1;
      if (i == v.stall_n - 1) stall = 1'b0;
      @(negedge clk);
    end
    check({tag, ".done_resp"}, resp, 1'b1);
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    @(negedge clk);
    check({tag, ".rdata"}, rdata, v.exp_rdata);
    check({tag, ".ready"}, ready, v.exp_ready);
    check({tag, ".idle_resp"}, resp, 1'b1);
    check({tag, ".n_access"}, acc_log.size() - base, v.exp_nacc);
    if (v.exp_nacc >= 1 && acc_log.size() > base) begin
      check({tag, ".acc0_we"}, acc_log[base].we, v.exp_acc0.we);
      check({tag, ".acc0_addr"}, acc_log[base].addr, v.exp_acc0.addr);
      check({tag, ".acc0_data"}, acc_log[base].data, v.exp_acc0.data);
    end
    if (v.exp_nacc >= 2 && acc_log.size() > base + 1) begin
      check({tag, ".acc1_we"}, acc_log[base+1].we, v.exp_acc1.we);
      check({tag, ".acc1_addr"}, acc_log[base+1].addr, v.exp_acc1.addr);
      check({tag, ".acc1_data"}, acc_log[base+1].data, v.exp_acc1.data);
    end
    exp_rdata_cur = v.exp_rdata;
    exp_ready_cur = v.exp_ready;
    $display("[TB] txn %s rd=%0b wr=%0b addr=%h be=%h wd=%h stall=%0d done@%0d rdata=%h",
             tag, v.rd, v.wr, v.addr, v.be, v.wd, v.stall_n, cyc, rdata);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t rv;
    int k, r;

    vecs[0] = mk(1, 0, 32'h100, 4'h0, 32'h0, 0, 3, 0, 5, 1,
                 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 1);
    vecs[1] = mk(0, 1, 32'h200, 4'h2, 32'h0000AB00, 0, 1, 2, 6, 2,
                 0, 32'h200, 32'h11223344, 1, 32'h200, 32'h1122AB44, 32'hDEADBEEF, 1);
    vecs[2] = mk(0, 1, 32'h300, 4'hF, 32'hCAFEF00D, 0, 2, 0, 4, 1,
                 1, 32'h300, 32'hCAFEF00D, 0, 0, 0, 32'hDEADBEEF, 1);
    vecs[3] = mk(1, 0, 32'h300, 4'h0, 32'h0, 4, 0, 0, 2, 1,
                 0, 32'h300, 32'hCAFEF00D, 0, 0, 0, 32'hCAFEF00D, 1);
    vecs[4] = mk(1, 1, 32'h203, 4'h8, 32'h77000000, 0, 0, 0, 3, 2,
                 0, 32'h200, 32'h1122AB44, 1, 32'h200, 32'h7722AB44, 32'hCAFEF00D, 1);
    vecs[5] = mk(1, 1, 32'h100, 4'h0, 32'h12345678, 1, 0, 0, 1, 0,
                 0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 1);
    vecs[6] = mk(1, 0, 32'h203, 4'h0, 32'h0, 0, 0, 0, 2, 1,
                 0, 32'h200, 32'h7722AB44, 0, 0, 0, 32'h7722AB44, 1);

    // Reset state.
    #1;
    check("reset.resp", resp, 1'b1);
    check("reset.ready", ready, 1'b0);
    check("reset.rdata", rdata, 32'h0);
    check("reset.strobes", {pmem_read, pmem_write}, 2'b00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("dir%0d", i));

    // Randomized transactions in a region the directed vectors never touch.
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 3);
      rv.rd = (k == 0) || (k == 2);
      rv.wr = (k != 0);
      rv.addr = 32'h1000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      r = $urandom_range(0, 5);
      rv.be = (r == 0) ? 4'h0 : (r == 1) ? 4'hF : 4'($urandom_range(1, 14));
      rv.wd = $urandom;
      rv.stall_n = $urandom_range(0, 2);
      rv.wa = $urandom_range(0, 3);
      rv.wb = $urandom_range(0, 3);
      predict(rv);
      run_vec(rv, $sformatf("rnd%0d", n));
    end

    // Reset asserted in the middle of a read access.
    @(posedge clk); #1;
    txn_base = acc_log.size();
    wait_a = 20;
    read = 1'b1; address = 32'h400;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid.pre_strobe", pmem_read, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid.pmem_read", pmem_read, 1'b0);
    check("rst_mid.pmem_write", pmem_write, 1'b0);
    check("rst_mid.rdata", rdata, 32'h0);
    check("rst_mid.ready", ready, 1'b0);
    read = 1'b0;
    #1;
    check("rst_mid.idle_resp", resp, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid.after_resp", resp, 1'b1);
    check("rst_mid.after_strobe", pmem_read, 1'b0);
    $display("[TB] txn rst_mid addr=00000400 reset during RD");
    exp_rdata_cur = 32'h0;
    exp_ready_cur = 1'b0;
    run_vec(mk(1, 0, 32'h100, 4'h0, 32'h0, 0, 1, 0, 3, 1,
               0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 1), "post_rst");

    check("pmem_protocol_errors", proto_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
